// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants and types for the pipeline control unit:
//                stall encodings, FSM state codes, bus widths and the
//                reset level.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Instruction address bus width and the all-zero word
    localparam int                 INST_ADDR_W = 32;
    localparam logic [31:0]        ZERO_WORD   = 32'h0000_0000;

    // Reset is asserted when rst equals this level
    localparam logic               RST_ENABLE  = 1'b0;

    // Hold vectors: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved
    localparam int                 STALL_W     = 6;
    localparam logic [STALL_W-1:0] STALL_MEM   = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX    = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID    = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_NONE  = 6'b000000;

    // Control FSM states
    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_DIV       = 2'd1,
        S_EXCP_WAIT = 2'd2
    } state_t;

    // Stall vector for a running stage, honouring mem > divide > id priority
    function automatic logic [STALL_W-1:0] stall_sel(
        input logic mem,
        input logic div,
        input logic id
    );
        if (mem)      return STALL_MEM;
        else if (div) return STALL_EX;
        else if (id)  return STALL_ID;
        else          return STALL_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Request/response bundle between the datapath and the
//                pipeline control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    // Requests from the datapath
    logic                   stallreq_id;
    logic                   stallreq_mem;
    logic                   div_start;
    logic                   excp_req;
    logic [INST_ADDR_W-1:0] excp_vec;

    // Control back to the datapath
    logic [STALL_W-1:0]     stall;
    logic                   flush;
    logic [INST_ADDR_W-1:0] new_pc;
    logic                   div_done;
    logic                   div_abort;
    logic [31:0]            perf_stall_cnt;

    // Datapath side
    modport master (
        output stallreq_id, stallreq_mem, div_start, excp_req, excp_vec,
        input  stall, flush, new_pc, div_done, div_abort, perf_stall_cnt
    );

    // Control unit side
    modport slave (
        input  stallreq_id, stallreq_mem, div_start, excp_req, excp_vec,
        output stall, flush, new_pc, div_done, div_abort, perf_stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous active-low reset that sticks at
//                all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);
    import pipe_ctrl_pkg::*;

    logic [WIDTH-1:0] r_count;

    // Count requested cycles, freezing once every bit is set
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central pipeline control for the 5-stage in-order core.
//                Converts stall, divide and exception requests into the
//                per-stage hold vector, a one-cycle flush with PC redirect,
//                divide completion/abort, and a stall-cycle perf counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  bus
);

    // Last counter value of a divide; the div_start cycle is the first stalled cycle
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [INST_ADDR_W-1:0] r_vec;
    logic [INST_ADDR_W-1:0] w_vec_nxt;

    logic [STALL_W-1:0]     w_stall;
    logic                   w_flush;
    logic [INST_ADDR_W-1:0] w_new_pc;
    logic                   w_div_done;
    logic                   w_div_abort;
    logic [31:0]            w_perf;

    // Zero-latency outputs and next-state decode; everything is quiet in reset
    always_comb begin
        w_stall     = STALL_NONE;
        w_flush     = 1'b0;
        w_new_pc    = ZERO_WORD;
        w_div_done  = 1'b0;
        w_div_abort = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;

        if (rst != RST_ENABLE) begin
            case (r_state)
                S_RUN: begin
                    if (bus.excp_req) begin
                        // Redirect now, or park the vector until memory is free
                        if (!bus.stallreq_mem) begin
                            w_flush  = 1'b1;
                            w_new_pc = bus.excp_vec;
                        end else begin
                            w_stall     = STALL_MEM;
                            w_vec_nxt   = bus.excp_vec;
                            w_state_nxt = S_EXCP_WAIT;
                        end
                    end else if (bus.div_start) begin
                        w_stall     = stall_sel(bus.stallreq_mem, 1'b1, 1'b0);
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DIV;
                    end else begin
                        w_stall = stall_sel(bus.stallreq_mem, 1'b0, bus.stallreq_id);
                    end
                end

                S_DIV: begin
                    if (bus.excp_req) begin
                        // Kill the divide; never reported as done in the same cycle
                        w_div_abort = 1'b1;
                        w_cnt_nxt   = '0;
                        if (!bus.stallreq_mem) begin
                            w_flush     = 1'b1;
                            w_new_pc    = bus.excp_vec;
                            w_state_nxt = S_RUN;
                        end else begin
                            w_stall     = STALL_MEM;
                            w_vec_nxt   = bus.excp_vec;
                            w_state_nxt = S_EXCP_WAIT;
                        end
                    end else if (r_cnt < C_CNT_LAST) begin
                        // Decode is already held by STALL_EX, so stallreq_id is moot
                        w_stall   = stall_sel(bus.stallreq_mem, 1'b1, 1'b0);
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else begin
                        // Result ready; hold it while memory still waits
                        w_div_done = 1'b1;
                        if (bus.stallreq_mem) begin
                            w_stall = STALL_MEM;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                end

                S_EXCP_WAIT: begin
                    // First exception wins; later excp_req/div_start are ignored
                    if (bus.stallreq_mem) begin
                        w_stall = STALL_MEM;
                    end else begin
                        w_flush     = 1'b1;
                        w_new_pc    = r_vec;
                        w_state_nxt = S_RUN;
                    end
                end

                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    // State, divide counter and parked exception vector
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_vec   <= ZERO_WORD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    sat_counter #(
        .WIDTH (32)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall[0]),
        .count (w_perf)
    );

    assign bus.stall          = w_stall;
    assign bus.flush          = w_flush;
    assign bus.new_pc         = w_new_pc;
    assign bus.div_done       = w_div_done;
    assign bus.div_abort      = w_div_abort;
    assign bus.perf_stall_cnt = w_perf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam logic [5:0] C_MEM  = 6'b011111;
    localparam logic [5:0] C_EX   = 6'b001111;
    localparam logic [5:0] C_ID   = 6'b000111;
    localparam logic [5:0] C_NONE = 6'b000000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle; inputs are applied 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_id  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.div_start    = 1'b0;
        bus.excp_req     = 1'b0;
        bus.excp_vec     = 32'h0;
    endtask

    // Two cycles of reset, leaving the bench at the start of a fresh cycle
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        bus.stallreq_id = 1'b1;
        @(negedge clk);
        total++;
        if (bus.stall !== C_NONE) begin
            bad++; $display("FAIL reset_stall_masked got=%b exp=%b", bus.stall, C_NONE);
        end
        tick();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (bus.stall !== C_NONE || bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
            bad++; $display("FAIL reset_idle stall=%b flush=%b new_pc=%h exp 0/0/0",
                            bus.stall, bus.flush, bus.new_pc);
        end
        total++;
        if (bus.perf_stall_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_perf got=%0d exp=0", bus.perf_stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.stallreq_id = 1'b1;
        @(negedge clk);
        total++;
        if (bus.stall !== C_ID) begin
            bad++; $display("FAIL load_use_stall got=%b exp=%b", bus.stall, C_ID);
        end
        tick();
        bus.stallreq_id = 1'b0;
        @(negedge clk);
        total++;
        if (bus.stall !== C_NONE || bus.perf_stall_cnt !== 32'd1) begin
            bad++; $display("FAIL load_use_after stall=%b perf=%0d exp stall=%b perf=1",
                            bus.stall, bus.perf_stall_cnt, C_NONE);
        end
    endtask

    task automatic test_divide();
        int errs;
        do_reset();
        errs = 0;
        // Cycle 0 is the div_start cycle, cycles 1..31 carry cnt 0..30
        for (int c = 0; c < 32; c++) begin
            bus.div_start   = (c == 0);
            bus.stallreq_id = (c == 5);
            @(negedge clk);
            if (bus.stall !== C_EX || bus.div_done !== 1'b0) begin
                errs++;
                if (errs == 1)
                    $display("FAIL divide_stall cycle=%0d stall=%b done=%b exp %b/0",
                             c, bus.stall, bus.div_done, C_EX);
            end
            tick();
        end
        total++;
        if (errs != 0) bad++;
        idle_inputs();
        @(negedge clk);
        total++;
        if (bus.div_done !== 1'b1 || bus.stall !== C_NONE) begin
            bad++; $display("FAIL divide_done done=%b stall=%b exp 1/%b",
                            bus.div_done, bus.stall, C_NONE);
        end
        tick();
        bus.stallreq_id = 1'b1;
        @(negedge clk);
        total++;
        if (bus.div_done !== 1'b0 || bus.stall !== C_ID || bus.perf_stall_cnt !== 32'd32) begin
            bad++; $display("FAIL divide_after done=%b stall=%b perf=%0d exp 0/%b/32",
                            bus.div_done, bus.stall, bus.perf_stall_cnt, C_ID);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_div_mem_wait();
        int errs;
        do_reset();
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        // Cycles 1..31 run the counter from 0 to 30
        for (int c = 1; c < 32; c++) tick();
        errs = 0;
        // Cycles 32..34 sit at the last count with memory busy
        for (int c = 32; c < 35; c++) begin
            bus.stallreq_mem = 1'b1;
            bus.div_start    = (c == 33);
            @(negedge clk);
            if (bus.stall !== C_MEM || bus.div_done !== 1'b1) begin
                errs++;
                if (errs == 1)
                    $display("FAIL divmem_hold cycle=%0d stall=%b done=%b exp %b/1",
                             c, bus.stall, bus.div_done, C_MEM);
            end
            tick();
        end
        total++;
        if (errs != 0) bad++;
        idle_inputs();
        @(negedge clk);
        total++;
        if (bus.div_done !== 1'b1 || bus.stall !== C_NONE) begin
            bad++; $display("FAIL divmem_release done=%b stall=%b exp 1/%b",
                            bus.div_done, bus.stall, C_NONE);
        end
        tick();
        bus.stallreq_id = 1'b1;
        @(negedge clk);
        total++;
        if (bus.div_done !== 1'b0 || bus.stall !== C_ID || bus.perf_stall_cnt !== 32'd35) begin
            bad++; $display("FAIL divmem_run done=%b stall=%b perf=%0d exp 0/%b/35",
                            bus.div_done, bus.stall, bus.perf_stall_cnt, C_ID);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_excp_mid_div();
        int errs;
        do_reset();
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        // Cycles 1..10 carry cnt 0..9; cycle 11 is cnt == 10
        for (int c = 1; c < 11; c++) tick();
        bus.excp_req = 1'b1;
        bus.excp_vec = 32'h0000_0180;
        @(negedge clk);
        total++;
        if (bus.div_abort !== 1'b1 || bus.flush !== 1'b1 || bus.new_pc !== 32'h180 ||
            bus.stall !== C_NONE || bus.div_done !== 1'b0) begin
            bad++; $display("FAIL excp_div abort=%b flush=%b new_pc=%h stall=%b done=%b exp 1/1/180/0/0",
                            bus.div_abort, bus.flush, bus.new_pc, bus.stall, bus.div_done);
        end
        tick();
        idle_inputs();
        errs = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.div_done !== 1'b0 || bus.div_abort !== 1'b0 || bus.stall !== C_NONE ||
                bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
                errs++;
                if (errs == 1)
                    $display("FAIL excp_div_after cycle=%0d done=%b abort=%b stall=%b flush=%b new_pc=%h exp all 0",
                             c, bus.div_done, bus.div_abort, bus.stall, bus.flush, bus.new_pc);
            end
            tick();
        end
        total++;
        if (errs != 0) bad++;
    endtask

    // Memory busy in cycles 1..4, exceptions in cycles 1 and 2; optional reset in cycle 3
    task automatic run_excp_wait(input logic with_reset);
        int errs;
        do_reset();
        tick();
        errs = 0;
        for (int c = 1; c < 5; c++) begin
            bus.stallreq_mem = 1'b1;
            bus.excp_req     = (c == 1) || (c == 2);
            bus.excp_vec     = (c == 1) ? 32'h200 : ((c == 2) ? 32'h300 : 32'h0);
            bus.div_start    = (c == 3);
            rst              = (with_reset && c == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.flush !== 1'b0 ||
                bus.stall !== ((with_reset && c == 3) ? C_NONE : C_MEM)) begin
                errs++;
                if (errs == 1)
                    $display("FAIL excp_wait_hold rst_case=%0b cycle=%0d flush=%b stall=%b",
                             with_reset, c, bus.flush, bus.stall);
            end
            tick();
        end
        total++;
        if (errs != 0) bad++;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (with_reset) begin
            if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
                bad++; $display("FAIL excp_wait_reset_drop flush=%b new_pc=%h exp 0/0",
                                bus.flush, bus.new_pc);
            end
        end else begin
            if (bus.flush !== 1'b1 || bus.new_pc !== 32'h200 || bus.stall !== C_NONE) begin
                bad++; $display("FAIL excp_wait_flush flush=%b new_pc=%h stall=%b exp 1/200/%b",
                                bus.flush, bus.new_pc, bus.stall, C_NONE);
            end
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.flush !== 1'b0 || bus.stall !== C_NONE) begin
            bad++; $display("FAIL excp_wait_after rst_case=%0b flush=%b stall=%b exp 0/%b",
                            with_reset, bus.flush, bus.stall, C_NONE);
        end
        tick();
    endtask

    task automatic test_excp_wait();
        run_excp_wait(1'b0);
        run_excp_wait(1'b1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_divide();
        test_div_mem_wait();
        test_excp_mid_div();
        test_excp_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
